// File: rtl/adc_spi_sequencer_if.sv
// Avalon-MM slave bus bundle for the ADC sequencer.
// The master drives address/strobes/data and the slave returns readdata.
interface adc_spi_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/adc_spi_sequencer.sv
// SPI mode-0 read-only sequencer for an MCP3201-style ADC behind an Avalon-MM slave.
// Frames single-shot or continuous conversions, latches the result and raises a level irq.
module adc_spi_sequencer #(
  parameter int DIV        = 25,
  parameter int FRAME_BITS = 15,
  parameter int DATA_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  adc_spi_sequencer_if.slave   bus,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  input  logic                 adc_miso,
  output logic                 irq
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt;
  logic [7:0]              div_cnt_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [FRAME_BITS-1:0]   shift_r;
  logic [DATA_BITS-1:0]    data_r;
  logic                    start_r;
  logic                    cont_r;
  logic                    ien_r;
  logic                    done_r;
  logic                    miso_meta_r;
  logic                    miso_sync_r;

  logic                    cs_n_nxt;
  logic                    sclk_nxt;
  logic                    tick_s;
  logic                    cnt_clr_s;
  logic                    shift_en_s;
  logic                    bit_inc_s;
  logic                    frame_end_s;
  logic                    busy_s;
  logic                    wr_s;
  logic                    ctrl_wr_s;
  logic                    stat_wr_s;
  logic                    done_nxt_s;
  logic                    ien_nxt_s;
  logic [31:0]             rd_mux_s;
  logic                    unused_wd_s;

  assign tick_s      = (div_cnt_r == 8'(DIV - 1));
  assign busy_s      = (state_r != IDLE);
  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign ctrl_wr_s   = wr_s & (bus.address == 2'd1);
  assign stat_wr_s   = wr_s & (bus.address == 2'd2);
  assign unused_wd_s = ^bus.writedata[31:3];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and per-phase strobes; pin levels are computed here and registered below.
  always_comb begin
    state_nxt   = state_r;
    cs_n_nxt    = adc_cs_n;
    sclk_nxt    = adc_sclk;
    cnt_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    bit_inc_s   = 1'b0;
    frame_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b0;
        cnt_clr_s = 1'b1;
        if (start_r || cont_r) begin
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (tick_s) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          state_nxt = SETUP;
        end
      end
      SHIFT: begin
        if (tick_s) begin
          cnt_clr_s = 1'b1;
          if (adc_sclk) begin
            sclk_nxt   = 1'b0;
            shift_en_s = 1'b1;
          end else if (bit_cnt_r == BIT_W'(FRAME_BITS - 1)) begin
            frame_end_s = 1'b1;
            cs_n_nxt    = 1'b1;
            state_nxt   = HOLD;
          end else begin
            sclk_nxt  = 1'b1;
            bit_inc_s = 1'b1;
          end
        end else begin
          state_nxt = SHIFT;
        end
      end
      HOLD: begin
        if (tick_s) begin
          cnt_clr_s = 1'b1;
          // Continuous mode skips IDLE so the frame period stays at 2*DIV*FRAME_BITS + 2*DIV.
          if (cont_r) begin
            state_nxt = SETUP;
            cs_n_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = IDLE;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b0;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Sticky done (a frame-end set beats a same-cycle clear) and the ien value seen by irq.
  always_comb begin
    if (frame_end_s) begin
      done_nxt_s = 1'b1;
    end else if (stat_wr_s && bus.writedata[1]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
    if (ctrl_wr_s) begin
      ien_nxt_s = bus.writedata[2];
    end else begin
      ien_nxt_s = ien_r;
    end
  end

  // SPI pins, timing counters, MISO synchronizer, shift register and result latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b0;
      div_cnt_r   <= 8'd0;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      data_r      <= '0;
      miso_meta_r <= 1'b0;
      miso_sync_r <= 1'b0;
    end else begin
      adc_cs_n    <= cs_n_nxt;
      adc_sclk    <= sclk_nxt;
      miso_meta_r <= adc_miso;
      miso_sync_r <= miso_meta_r;
      div_cnt_r   <= cnt_clr_s ? 8'd0 : (div_cnt_r + 8'd1);
      if (state_r != SHIFT) begin
        bit_cnt_r <= '0;
      end else if (bit_inc_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (shift_en_s) begin
        shift_r <= {shift_r[FRAME_BITS-2:0], miso_sync_r};
      end else begin
        shift_r <= shift_r;
      end
      if (frame_end_s) begin
        data_r <= shift_r[DATA_BITS-1:0];
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Register file, interrupt and registered read mux.
  always_comb begin
    rd_mux_s = 32'd0;
    case (bus.address)
      2'd0:    rd_mux_s = {{(32 - DATA_BITS){1'b0}}, data_r};
      2'd1:    rd_mux_s = {29'd0, ien_r, cont_r, 1'b0};
      2'd2:    rd_mux_s = {30'd0, done_r, busy_s};
      default: rd_mux_s = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_r      <= 1'b0;
      cont_r       <= 1'b0;
      ien_r        <= 1'b0;
      done_r       <= 1'b0;
      irq          <= 1'b0;
      bus.readdata <= 32'd0;
    end else begin
      // A start while busy is dropped, never queued.
      start_r      <= ctrl_wr_s & bus.writedata[0] & ~busy_s;
      if (ctrl_wr_s) begin
        cont_r <= bus.writedata[1];
      end else begin
        cont_r <= cont_r;
      end
      ien_r        <= ien_nxt_s;
      done_r       <= done_nxt_s;
      irq          <= done_nxt_s & ien_nxt_s;
      bus.readdata <= rd_mux_s;
    end
  end

endmodule

// File: doc/adc_spi_sequencer.md
# adc_spi_sequencer

Avalon-MM slave that sequences an external serial ADC (MCP3201-style, SPI mode 0, read-only) measuring the actuator position of the tiller control loop. It drives the ADC chip select, serial clock and samples MISO. It frames single-shot or continuous conversions, latches the result into a readable register and raises an interrupt on completion. It replaces polling of the raw chip-select PIO by software and sits on the same SOPC bus as the other PIO peripherals.

## Interface
- DIV, 25: clk cycles per SCLK half-period (50 MHz → 1 MHz SCLK); legal range 3..255.
- FRAME_BITS, 15: SCLK rising edges per conversion frame.
- DATA_BITS, 12: result width; the last DATA_BITS bits of the frame, MSB first.
- clk  in  1  system clock; every register on its rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- address  in  2  register select: 0 DATA, 1 CTRL, 2 STATUS, 3 reserved.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read mux, updated every cycle from address.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idle low.
- adc_miso  in  1  ADC serial data; asynchronous, goes through a 2-flop synchronizer.
- irq  out  1  level interrupt = done & ien.

## Operation
- **Registers:**
  - DATA (RO): bits [DATA_BITS-1:0] hold the last result, upper bits 0. Writes are ignored.
  - CTRL (RW): bit0 start (write-1 pulse, reads 0), bit1 cont, bit2 ien.
  - STATUS: bit0 busy (RO); bit1 done (sticky). Writing 1 to bit1 clears done.
  - Address 3 reads 0.
- **FSM states:** IDLE, SETUP, SHIFT, HOLD.
- **IDLE:** adc_cs_n=1, adc_sclk=0, busy=0. Goes to SETUP when start is written with 1, or when cont=1.
- **SETUP:** adc_cs_n=0 for DIV cycles, then SHIFT.
- **SHIFT:** each bit is adc_sclk=1 for DIV cycles, then 0 for DIV cycles.
  - The synchronized MISO is shifted into the FRAME_BITS-bit shift register on the clk edge where adc_sclk goes 1→0.
  - A bit counter counts 0..FRAME_BITS-1.
  - After the low phase of the last bit: DATA ← shift[DATA_BITS-1:0], done ← 1, go to HOLD.
- **HOLD:** adc_cs_n=1 for DIV cycles, then IDLE.
- busy=1 in SETUP, SHIFT and HOLD.
- **Boundary conditions:**
  - A start written while busy is ignored (not queued).
  - Clearing cont mid-frame completes the current frame, then stops.
  - If done is set and cleared in the same cycle, set wins.
  - DATA changes only at frame end; a partial frame never updates DATA.
  - Reset mid-frame abandons the frame: on the next edge adc_cs_n=1, adc_sclk=0, state IDLE, shift register and counters cleared.
- **Reset values:**
  - readdata=0, adc_cs_n=1, adc_sclk=0, irq=0.
  - DATA=0, CTRL=0, done=0, state IDLE.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- **readdata:** reflects the value selected by address at edge N on the edge after N (1-cycle latency, no wait states). Writes take effect on the edge where chipselect=1 and write_n=0.
- **Frame timing**, with the start write accepted at edge T:
  - adc_cs_n=0 from T+1.
  - First adc_sclk rise at T+1+DIV.
  - done=1 at T+1+DIV+2·DIV·FRAME_BITS.
  - adc_cs_n=1 from that same edge.
  - IDLE at +DIV more.
- Defaults: done at T+776, next frame (cont) may start at T+801; frame period 800 cycles.
- **MISO:** 2-flop synchronizer latency is 2 cycles. MISO is sampled DIV cycles after the SCLK rise, so data must be valid within DIV-2 cycles of the rise.
- irq follows done with no extra latency (same edge when ien=1).

## Test plan
- Reset with ADC model returning 0x0A5C (12 bits after 3 leading nulls), then write CTRL=0x1 → adc_cs_n low at T+1; 15 SCLK pulses of 25/25 cycles; done=1 at T+776; DATA reads 0x00000A5C; irq stays 0 (ien=0).
- CTRL=0x5, ADC returns 0xFFF → irq=1 at done. Write STATUS=0x2 → irq=0 next cycle; STATUS reads 0x0.
- CTRL=0x2 (cont), model alternates 0x123/0x456 → back-to-back frames 800 cycles apart. DATA alternates 0x123, 0x456. Clear cont mid-frame → exactly one more update, then busy=0.
- Write start again at T+100 during a frame → ignored: one frame only, done timing unchanged.
- Assert reset_n=0 for 1 cycle at T+300 → next edge adc_cs_n=1, adc_sclk=0, busy=0; DATA=0, readdata=0. A new start runs a full, correct frame.
- Read address 3 and write to DATA → readdata=0 for address 3; DATA unchanged.
